// File: rtl/wb_regfile.sv
// wb_regfile -- write-back stage register feeding a 32 x 32-bit register file.
//
// A memory-stage result {mem_wd, mem_wreg, mem_wdata} is captured into the
// write-back stage register. On the following edge, the captured write is
// committed to storage. Two independent combinational read ports are provided.
//
// Ports
//   clk                    rising-edge clock
//   rst                    asynchronous active-high reset (clears stage + storage)
//   mem_wd/mem_wreg/mem_wdata  write request from the memory stage
//   stall                  hold the stage register (the pending write repeats)
//   flush                  load a bubble into the stage register (wins over stall)
//   re1/raddr1, re2/raddr2 read enables and addresses
//   rdata1, rdata2         combinational read data (0 when disabled or addr 0)
//   wb_wd/wb_wreg/wb_wdata stage register contents
//
// Build option
//   REGFILE_BYPASS_EN  when defined, a read that hits the pending write returns
//                      wb_wdata in the same cycle. Otherwise a read returns the
//                      old storage value until the write edge has passed.
module wb_regfile (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  mem_wd,
  input  logic        mem_wreg,
  input  logic [31:0] mem_wdata,
  input  logic        stall,
  input  logic        flush,
  input  logic        re1,
  input  logic [4:0]  raddr1,
  input  logic        re2,
  input  logic [4:0]  raddr2,
  output logic [31:0] rdata1,
  output logic [31:0] rdata2,
  output logic [4:0]  wb_wd,
  output logic        wb_wreg,
  output logic [31:0] wb_wdata
);

  // ---------------------------------------------------------------------------
  // Write-back stage register
  // ---------------------------------------------------------------------------
  logic [4:0]  wb_wd_q,    wb_wd_d;
  logic        wb_wreg_q,  wb_wreg_d;
  logic [31:0] wb_wdata_q, wb_wdata_d;

  always_comb begin
    wb_wd_d    = wb_wd_q;
    wb_wreg_d  = wb_wreg_q;
    wb_wdata_d = wb_wdata_q;
    if (flush) begin
      // Bubble: flush wins even if stall is also set.
      wb_wd_d    = 5'd0;
      wb_wreg_d  = 1'b0;
      wb_wdata_d = 32'd0;
    end else if (!stall) begin
      wb_wd_d    = mem_wd;
      wb_wreg_d  = mem_wreg;
      wb_wdata_d = mem_wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_wd_q    <= 5'd0;
      wb_wreg_q  <= 1'b0;
      wb_wdata_q <= 32'd0;
    end else begin
      wb_wd_q    <= wb_wd_d;
      wb_wreg_q  <= wb_wreg_d;
      wb_wdata_q <= wb_wdata_d;
    end
  end

  assign wb_wd    = wb_wd_q;
  assign wb_wreg  = wb_wreg_q;
  assign wb_wdata = wb_wdata_q;

  // ---------------------------------------------------------------------------
  // Storage. Entry 0 is never written, so it stays at its reset value; the
  // read ports also force address 0 to zero independently of storage.
  // A held stage (stall) rewrites the same value each edge, which is harmless.
  // ---------------------------------------------------------------------------
  logic [31:0] regs_q [32];
  logic        wr_en;

  assign wr_en = wb_wreg_q && (wb_wd_q != 5'd0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) regs_q[i] <= 32'd0;
    end else if (wr_en) begin
      regs_q[wb_wd_q] <= wb_wdata_q;
    end
  end

  // ---------------------------------------------------------------------------
  // Read ports
  // ---------------------------------------------------------------------------
`ifdef REGFILE_BYPASS_EN
  logic hit1, hit2;
  assign hit1 = wb_wreg_q && (raddr1 == wb_wd_q);
  assign hit2 = wb_wreg_q && (raddr2 == wb_wd_q);

  always_comb begin
    rdata1 = 32'd0;
    if (re1 && (raddr1 != 5'd0)) rdata1 = hit1 ? wb_wdata_q : regs_q[raddr1];
  end

  always_comb begin
    rdata2 = 32'd0;
    if (re2 && (raddr2 != 5'd0)) rdata2 = hit2 ? wb_wdata_q : regs_q[raddr2];
  end
`else
  always_comb begin
    rdata1 = 32'd0;
    if (re1 && (raddr1 != 5'd0)) rdata1 = regs_q[raddr1];
  end

  always_comb begin
    rdata2 = 32'd0;
    if (re2 && (raddr2 != 5'd0)) rdata2 = regs_q[raddr2];
  end
`endif

endmodule

// File: tb/tb_wb_regfile.sv
// Directed self-checking bench for wb_regfile. Inputs change 1 time unit after
// a rising edge; outputs are checked 1 time unit after the inputs change.
module tb_wb_regfile;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  mem_wd;
  logic        mem_wreg;
  logic [31:0] mem_wdata;
  logic        stall, flush;
  logic        re1, re2;
  logic [4:0]  raddr1, raddr2;
  logic [31:0] rdata1, rdata2;
  logic [4:0]  wb_wd;
  logic        wb_wreg;
  logic [31:0] wb_wdata;

  int total = 0;
  int bad   = 0;

  wb_regfile dut (
    .clk(clk), .rst(rst),
    .mem_wd(mem_wd), .mem_wreg(mem_wreg), .mem_wdata(mem_wdata),
    .stall(stall), .flush(flush),
    .re1(re1), .raddr1(raddr1), .re2(re2), .raddr2(raddr2),
    .rdata1(rdata1), .rdata2(rdata2),
    .wb_wd(wb_wd), .wb_wreg(wb_wreg), .wb_wdata(wb_wdata)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_wb(input string tag, input logic [4:0] wd, input logic wr, input logic [31:0] wdat);
    check({tag, ".wd"},    {27'd0, wb_wd},   {27'd0, wd});
    check({tag, ".wreg"},  {31'd0, wb_wreg}, {31'd0, wr});
    check({tag, ".wdata"}, wb_wdata,         wdat);
  endtask

  // Combinational read on port 1, checked after settling.
  task automatic rd1(input string tag, input logic [4:0] a, input logic [31:0] exp);
    re1 = 1'b1; raddr1 = a; #1;
    check(tag, rdata1, exp);
  endtask

  task automatic set_mem(input logic [4:0] wd, input logic wr, input logic [31:0] d);
    mem_wd = wd; mem_wreg = wr; mem_wdata = d;
  endtask

  logic [31:0] exp_pend;

  initial begin
    rst = 1'b1; stall = 1'b0; flush = 1'b0;
    re1 = 1'b0; re2 = 1'b0; raddr1 = 5'd0; raddr2 = 5'd0;
    set_mem(5'd0, 1'b0, 32'd0);
    #2;
    check_wb("reset_stage", 5'd0, 1'b0, 32'd0);
    tick(); tick();
    rst = 1'b0;
    #1;
    for (int a = 1; a < 32; a++) rd1($sformatf("reset_r%0d", a), a[4:0], 32'd0);

    // Write r5 = DEADBEEF: stage after edge N, storage after edge N+1.
    set_mem(5'd5, 1'b1, 32'hDEADBEEF);
    tick();
    set_mem(5'd0, 1'b0, 32'd0);
    check_wb("wr5_stage", 5'd5, 1'b1, 32'hDEADBEEF);
`ifdef REGFILE_BYPASS_EN
    exp_pend = 32'hDEADBEEF;
`else
    exp_pend = 32'd0;
`endif
    rd1("wr5_pending", 5'd5, exp_pend);
    tick();
    rd1("wr5_done", 5'd5, 32'hDEADBEEF);

    // Zero register: writes to r0 pass the stage but never land.
    set_mem(5'd0, 1'b1, 32'h12345678);
    re2 = 1'b1; raddr2 = 5'd0;
    for (int c = 0; c < 3; c++) begin
      tick();
      rd1($sformatf("zero_p1_c%0d", c), 5'd0, 32'd0);
      check($sformatf("zero_p2_c%0d", c), rdata2, 32'd0);
    end
    check_wb("zero_stage", 5'd0, 1'b1, 32'h12345678);
    re2 = 1'b0;

    // Stall / flush.
    set_mem(5'd7, 1'b1, 32'hA5A5A5A5);
    tick();
    check_wb("stall_load", 5'd7, 1'b1, 32'hA5A5A5A5);
    stall = 1'b1;
    set_mem(5'd9, 1'b1, 32'h0000FFFF);
    for (int c = 0; c < 3; c++) begin
      tick();
      check_wb($sformatf("stall_hold%0d", c), 5'd7, 1'b1, 32'hA5A5A5A5);
    end
    rd1("stall_r7", 5'd7, 32'hA5A5A5A5);
    flush = 1'b1;
    tick();
    check_wb("flush_bubble", 5'd0, 1'b0, 32'd0);
    stall = 1'b0; flush = 1'b0;
    set_mem(5'd0, 1'b0, 32'd0);
    tick();
    rd1("flush_r7_kept", 5'd7, 32'hA5A5A5A5);
    rd1("flush_r9_none", 5'd9, 32'd0);

    // Bypass: r3 = 11111111 in storage, then CAFE pending in the stage.
    set_mem(5'd3, 1'b1, 32'h11111111);
    tick();
    set_mem(5'd3, 1'b1, 32'h0000CAFE);
    tick();
    set_mem(5'd0, 1'b0, 32'd0);
`ifdef REGFILE_BYPASS_EN
    exp_pend = 32'h0000CAFE;
`else
    exp_pend = 32'h11111111;
`endif
    re2 = 1'b1; raddr2 = 5'd3;
    rd1("byp_p1_pending", 5'd3, exp_pend);
    check("byp_p2_pending", rdata2, exp_pend);
    tick();
    check("byp_p2_done", rdata2, 32'h0000CAFE);
    rd1("byp_p1_done", 5'd3, 32'h0000CAFE);

    // Independent ports: different addresses at once.
    raddr2 = 5'd5; raddr1 = 5'd7; #1;
    check("indep_p1", rdata1, 32'hA5A5A5A5);
    check("indep_p2", rdata2, 32'hDEADBEEF);

    // Read disable.
    re1 = 1'b0; raddr1 = 5'd3; #1;
    check("rd_disable", rdata1, 32'd0);
    re2 = 1'b0; #1;
    check("rd_disable_p2", rdata2, 32'd0);

    // Reset mid-stall with a pending write to r10: write dropped, all cleared.
    set_mem(5'd10, 1'b1, 32'h00000077);
    tick();
    stall = 1'b1;
    #1 rst = 1'b1;
    #1;
    check_wb("rst_mid_stage", 5'd0, 1'b0, 32'd0);
    tick();
    rst = 1'b0; stall = 1'b0;
    set_mem(5'd0, 1'b0, 32'd0);
    rd1("rst_r5_cleared", 5'd5, 32'd0);
    rd1("rst_r7_cleared", 5'd7, 32'd0);
    tick();
    rd1("rst_r10_dropped", 5'd10, 32'd0);

    // First capture after reset release.
    set_mem(5'd11, 1'b1, 32'h00000055);
    tick();
    check_wb("post_rst_cap", 5'd11, 1'b1, 32'h00000055);
    set_mem(5'd0, 1'b0, 32'd0);
    tick();
    rd1("post_rst_r11", 5'd11, 32'h00000055);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
